if_stage: RTL and testbench

Instruction fetch stage for the RISC-V core. Holds the program counter, issues one instruction-memory request at a time, and registers the returned word into the IF/ID register. The registered `id_opcode` feeds the opcode input of the main control decoder. Redirects from branch resolution flush in-flight fetches.

---
 rtl/core_pkg.sv | 21 ++
 rtl/if_perf_cnt.sv | 22 ++
 rtl/if_stage.sv | 148 ++++++++++++++
 tb/tb_if_stage.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM states, NOP encoding and
// opcode constants used by the fetch stage and the control decoder.
package core_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } if_state_t;

    localparam logic [31:0] NOP    = 32'h0000_0013;

    localparam logic [6:0]  OP_R   = 7'b0110011;
    localparam logic [6:0]  OP_I   = 7'b0010011;
    localparam logic [6:0]  OP_LW  = 7'b0000011;
    localparam logic [6:0]  OP_SW  = 7'b0100011;
    localparam logic [6:0]  OP_BEQ = 7'b1100011;

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch performance counters: IF/ID loads and dropped responses.
// Only instantiated when IF_PERF_CNT_EN is defined.
module if_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_ev,
    input  logic        drop_ev,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (fetch_ev) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (drop_ev)  perf_drop_cnt  <= perf_drop_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem fetch, IF/ID reg.
// Define IF_PERF_CNT_EN to add the perf_fetch_cnt/perf_drop_cnt outputs.
module if_stage
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_drop_cnt
`endif
);

    if_state_t       state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] fetch_pc;
    logic [31:0]     buf_instr;
    logic            accept;
    logic            fetch_ev;
    logic [XLEN-1:0] new_pc;
    logic            unused_pc_lsb;

    assign new_pc        = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign imem_req_addr = pc;
    assign accept        = imem_req_valid && imem_req_ready;
    assign id_opcode     = id_instr[6:0];

    // A word reaches IF/ID straight from memory or from the hold buffer.
    always_comb begin
        fetch_ev = 1'b0;
        unique case (state)
            S_WAIT:  fetch_ev = imem_resp_valid && !redirect_valid
                                && (!stall || !id_valid);
            S_HOLD:  fetch_ev = !redirect_valid && !stall;
            default: fetch_ev = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            fetch_pc       <= RESET_PC;
            buf_instr      <= NOP;
            imem_req_valid <= 1'b0;
            id_valid       <= 1'b0;
            id_instr       <= NOP;
            id_pc          <= RESET_PC;
        end else begin
            if (redirect_valid || !stall) begin
                id_valid <= 1'b0;
                id_instr <= NOP;
            end
            if (fetch_ev) begin
                id_valid <= 1'b1;
                id_instr <= (state == S_HOLD) ? buf_instr : imem_resp_data;
                id_pc    <= fetch_pc;
            end
            if (redirect_valid) pc <= new_pc;
            unique case (state)
                S_IDLE: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
                S_REQ: begin
                    if (accept) begin
                        imem_req_valid <= 1'b0;
                        if (redirect_valid) begin
                            state <= S_DRAIN;
                        end else begin
                            pc       <= pc + XLEN'(4);
                            fetch_pc <= pc;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (redirect_valid && !imem_resp_valid) begin
                        state <= S_DRAIN;
                    end else if (redirect_valid || fetch_ev) begin
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end else if (imem_resp_valid) begin
                        buf_instr <= imem_resp_data;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || !stall) begin
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        state          <= S_REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    imem_req_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic drop_ev;

    always_comb begin
        drop_ev = 1'b0;
        unique case (1'b1)
            state == S_WAIT:  drop_ev = imem_resp_valid && redirect_valid;
            state == S_HOLD:  drop_ev = redirect_valid;
            state == S_DRAIN: drop_ev = imem_resp_valid;
            default:          drop_ev = 1'b0;
        endcase
    end

    if_perf_cnt u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_ev       (fetch_ev),
        .drop_ev        (drop_ev),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_drop_cnt  (perf_drop_cnt)
    );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: random memory/stall/redirect traffic
// against an instruction-stream reference model, plus directed cases.
module tb_if_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, resp_valid, redir, stall, id_valid;
    logic [31:0] req_addr, resp_data, redir_pc, id_instr, id_pc;
    logic [6:0]  id_opcode;

    logic        w_req_valid, w_ready, w_resp_valid, w_redir, w_stall;
    logic        w_id_valid;
    logic [31:0] w_req_addr, w_resp_data, w_redir_pc, w_id_instr, w_id_pc;
    logic [6:0]  w_id_opcode;

`ifdef IF_PERF_CNT_EN
    logic [31:0] pf, pd, w_pf, w_pd;
`endif

    if_stage u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (req_valid),
        .imem_req_ready  (req_ready),
        .imem_req_addr   (req_addr),
        .imem_resp_valid (resp_valid),
        .imem_resp_data  (resp_data),
        .redirect_valid  (redir),
        .redirect_pc     (redir_pc),
        .stall           (stall),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_opcode       (id_opcode)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (pf),
        .perf_drop_cnt   (pd)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (w_req_valid),
        .imem_req_ready  (w_ready),
        .imem_req_addr   (w_req_addr),
        .imem_resp_valid (w_resp_valid),
        .imem_resp_data  (w_resp_data),
        .redirect_valid  (w_redir),
        .redirect_pc     (w_redir_pc),
        .stall           (w_stall),
        .id_valid        (w_id_valid),
        .id_instr        (w_id_instr),
        .id_pc           (w_id_pc),
        .id_opcode       (w_id_opcode)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (w_pf),
        .perf_drop_cnt   (w_pd)
`endif
    );

    int          n_cmp = 0, n_bad = 0;
    int          cyc, pend_due, n_resp, n_cons, n_redir;
    bit          pend, w_pend, p_hold, p_redir, f_redir, f_redir_resp;
    logic [31:0] pend_addr, exp_req, exp_id, f_pc, p_pc, p_instr;
    logic [31:0] last_acc_addr, last_cons_pc;
    int          rdy_pct, dly_min, dly_max, stall_pct, redir_pct;
    int          f_stall = -1;
    int          f_late = 0;
    int          aq[$], vq[$];
    logic [31:0] wq[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: a pure function of the word address.
    function automatic logic [31:0] word(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd0:    op = OP_R;
            3'd1:    op = OP_I;
            3'd2:    op = OP_LW;
            3'd3:    op = OP_SW;
            default: op = OP_BEQ;
        endcase
        return {a[26:2] ^ 25'h0abcdef, op};
    endfunction

    // One clock cycle: drive inputs, check outputs, advance model.
    task automatic step();
        bit late, acc;
        late = 1'b0;
        req_ready = ($urandom_range(0, 99) < rdy_pct);
        if (f_late > 0) begin
            resp_valid = 1'b1;
            resp_data  = $urandom;
            late       = 1'b1;
            f_late--;
        end else begin
            resp_valid = pend && (cyc >= pend_due);
            resp_data  = resp_valid ? word(pend_addr) : $urandom;
        end
        stall = (f_stall >= 0) ? (f_stall != 0)
                               : ($urandom_range(0, 99) < stall_pct);
        redir = f_redir || (f_redir_resp && resp_valid)
                || ($urandom_range(0, 99) < redir_pct);
        redir_pc = (f_redir || f_redir_resp) ? f_pc
                                             : $urandom_range(0, 4095);
        w_ready      = 1'b1;
        w_resp_valid = w_pend;
        w_resp_data  = $urandom;
        #1;
        check("opcode", id_opcode, id_instr[6:0]);
        if (!id_valid) check("nop", id_instr, NOP);
        if (p_hold)
            check("hold", {id_valid, id_pc, id_instr}, {1'b1, p_pc, p_instr});
        if (p_redir) check("redir_clr", id_valid, 1'b0);
        if (id_valid) vq.push_back(cyc);
        if (id_valid && !stall) begin
            check("id_pc", id_pc, exp_id);
            check("id_instr", id_instr, word(exp_id));
            last_cons_pc = id_pc;
            exp_id += 32'd4;
            n_cons++;
        end
        if (resp_valid && !late) begin
            pend = 1'b0;
            n_resp++;
        end
        acc = req_valid && req_ready;
        if (acc) begin
            check("one_outstanding", pend, 1'b0);
            check("req_addr", req_addr, exp_req);
            aq.push_back(cyc);
            last_acc_addr = req_addr;
            pend      = 1'b1;
            pend_addr = req_addr;
            pend_due  = cyc + $urandom_range(dly_min, dly_max);
            exp_req  += 32'd4;
        end
        if (redir) begin
            exp_req = {redir_pc[31:2], 2'b00};
            exp_id  = exp_req;
            n_redir++;
        end
        p_hold  = id_valid && stall && !redir;
        p_pc    = id_pc;
        p_instr = id_instr;
        p_redir = redir;
        if (w_resp_valid) w_pend = 1'b0;
        if (w_req_valid) begin
            if (wq.size() < 4) wq.push_back(w_req_addr);
            w_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        pend = 1'b0; w_pend = 1'b0; p_hold = 1'b0; p_redir = 1'b0;
        exp_req = 32'h0; exp_id = 32'h0; n_resp = 0; f_late = 0;
        req_ready = 1'b0; resp_valid = 1'b0; redir = 1'b0; stall = 1'b0;
        w_ready = 1'b0; w_resp_valid = 1'b0;
        #1;
        check({tag, "_req_valid"}, req_valid, 1'b0);
        check({tag, "_req_addr"}, req_addr, 32'h0);
        check({tag, "_id_valid"}, id_valid, 1'b0);
        check({tag, "_id_instr"}, id_instr, 32'h0000_0013);
        check({tag, "_id_pc"}, id_pc, 32'h0);
        check({tag, "_id_opcode"}, id_opcode, 7'b0010011);
        check({tag, "_wrap_addr"}, w_req_addr, 32'hFFFF_FFFC);
`ifdef IF_PERF_CNT_EN
        check({tag, "_perf_fetch"}, pf, 32'h0);
        check({tag, "_perf_drop"}, pd, 32'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_acc(input string tag);
        int na, k;
        na = aq.size();
        k = 0;
        while (aq.size() == na && k < 60) begin
            step();
            k++;
        end
        check(tag, aq.size() > na, 1'b1);
    endtask

    task automatic wait_cons(input string tag);
        int nc, k;
        nc = n_cons;
        k = 0;
        while (n_cons == nc && k < 60) begin
            step();
            k++;
        end
        check(tag, n_cons > nc, 1'b1);
    endtask

    task automatic set_knobs(input int r, input int dmin, input int dmax,
                             input int s, input int d);
        rdy_pct = r; dly_min = dmin; dly_max = dmax;
        stall_pct = s; redir_pct = d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, k, nr;
        logic [31:0] hpc;
        w_redir = 1'b0; w_stall = 1'b0; w_redir_pc = 32'h0;
        f_redir = 1'b0; f_redir_resp = 1'b0; f_pc = 32'h0;
        n_cons = 0; n_redir = 0;
        set_knobs(100, 1, 1, 0, 0);
        #2;
        do_reset("rst");

        // Zero-wait memory: first request, latency and throughput.
        check("t1_idle_req", req_valid, 1'b0);
        aq.delete();
        vq.delete();
        repeat (8) step();
        check("t1_n_acc", aq.size() >= 2, 1'b1);
        check("t1_n_valid", vq.size() >= 3, 1'b1);
        if (aq.size() >= 2 && vq.size() >= 3) begin
            check("t1_first_req_cyc", aq[0], 1);
            check("t1_latency", vq[0] - aq[0], 2);
            check("t1_req_spacing", aq[1] - aq[0], 2);
            check("t1_valid_spacing0", vq[1] - vq[0], 2);
            check("t1_valid_spacing1", vq[2] - vq[1], 2);
        end
        check("wrap_n", wq.size() >= 2, 1'b1);
        if (wq.size() >= 2) begin
            check("wrap_addr0", wq[0], 32'hFFFF_FFFC);
            check("wrap_addr1", wq[1], 32'h0000_0000);
        end

        // Stall while a response returns: hold, then release.
        k = 0;
        while (!id_valid && k < 20) begin
            step();
            k++;
        end
        check("t2_found_valid", id_valid, 1'b1);
        hpc = id_pc;
        f_stall = 1;
        step();
        na = aq.size();
        repeat (4) step();
        check("t2_no_req", aq.size() - na, 0);
        check("t2_req_low", req_valid, 1'b0);
        f_stall = 0;
        step();
        check("t2_next_valid", id_valid, 1'b1);
        check("t2_next_pc", id_pc, hpc + 32'd4);
        f_stall = -1;

        // Redirect while waiting for a response.
        set_knobs(100, 3, 3, 0, 0);
        wait_acc("t3_acc0");
        check("t3_in_wait", req_valid, 1'b0);
        f_redir = 1'b1;
        f_pc = 32'h100;
        step();
        f_redir = 1'b0;
        wait_acc("t3_acc1");
        check("t3_addr", last_acc_addr, 32'h100);
        wait_cons("t3_cons");
        check("t3_first_pc", last_cons_pc, 32'h100);

        // Misaligned redirect coinciding with the response.
        set_knobs(100, 2, 2, 0, 0);
        wait_acc("t4_acc0");
        f_redir_resp = 1'b1;
        f_pc = 32'h203;
        nr = n_redir;
        k = 0;
        while (n_redir == nr && k < 20) begin
            step();
            k++;
        end
        f_redir_resp = 1'b0;
        check("t4_redir_seen", n_redir > nr, 1'b1);
        wait_acc("t4_acc1");
        check("t4_addr", last_acc_addr, 32'h200);
        wait_cons("t4_cons");
        check("t4_first_pc", last_cons_pc, 32'h200);

        // Random traffic against the stream model.
        nr = n_cons;
        for (int r = 0; r < 6; r++) begin
            set_knobs($urandom_range(30, 100), 1, $urandom_range(1, 4),
                      $urandom_range(0, 50), $urandom_range(0, 10));
            repeat (500) step();
        end
        set_knobs(0, 1, 1, 0, 0);
        repeat (20) step();
        check("rand_progress", (n_cons - nr) > 100, 1'b1);
`ifdef IF_PERF_CNT_EN
        check("perf_sum", pf + pd, n_resp);
`endif

        // Asynchronous reset in WAIT, then late responses.
        set_knobs(100, 4, 4, 0, 0);
        wait_acc("t6_acc");
        check("t6_in_wait", req_valid, 1'b0);
        #2;
        do_reset("mid");
        set_knobs(0, 1, 1, 0, 0);
        f_late = 2;
        step();
        step();
        check("t6_late_ignored", id_valid, 1'b0);
        check("t6_req_addr", req_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
        check("t6_perf_fetch", pf, 32'h0);
        check("t6_perf_drop", pd, 32'h0);
`endif
        set_knobs(100, 1, 1, 0, 0);
        wait_cons("t6_cons");
        check("t6_first_pc", last_cons_pc, 32'h0);
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
